// File: rtl/shifter_pkg.sv
// Shared types and constants for the sequential shifter.
// The rotate build is selected with SEQ_SHIFTER_ROTATE_EN.
package shifter_pkg;

  localparam int SHIFTER_WIDTH = 32;

  typedef enum logic [1:0] {
    SH_SRL = 2'b00,
    SH_SRA = 2'b01,
    SH_SLL = 2'b10,
    SH_ASL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Only a right arithmetic shift replicates the sign; left modes always fill with 0.
  function automatic logic mode_fill(input shift_mode_t mode, input logic sign);
    return !mode[1] && mode[0] && sign;
  endfunction

endpackage

// File: rtl/shift_step_1bit.sv
// Combinational single-position shift used once per clock by seq_shifter_32bits.
// With SEQ_SHIFTER_ROTATE_EN defined, a rotate input recirculates the MSB on left shifts.
module shift_step_1bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic             left,
  input  logic             fill,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q
);

  logic low_in;

`ifdef SEQ_SHIFTER_ROTATE_EN
  assign low_in = rotate ? data[WIDTH-1] : fill;
`else
  assign low_in = fill;
`endif

  assign q = left ? {data[WIDTH-2:0], low_in} : {fill, data[WIDTH-1:1]};

endmodule

// File: rtl/seq_shifter_32bits.sv
// Iterative SRL/SRA/SLL unit, one bit position per clock, valid/ready on both sides.
// Defining SEQ_SHIFTER_ROTATE_EN turns Sel=11 into rotate-left.
module seq_shifter_32bits
  import shifter_pkg::*;
#(
  parameter int WIDTH   = SHIFTER_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] B,
  input  logic [1:0]         Sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Y,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  shift_mode_t        mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   step_out;

  shift_step_1bit #(.WIDTH(WIDTH)) u_step (
    .data   (data_q),
    .left   (mode_q[1]),
    .fill   (mode_fill(mode_q, sign_q)),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rotate (mode_q == SH_ASL),
`endif
    .q      (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = A;
          cnt_d  = B;
          mode_d = shift_mode_t'(Sel);
          sign_d = A[WIDTH-1];
          if (B == '0) begin
            state_d = ST_DONE;
            y_d     = A;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_out;
        cnt_d  = cnt_q - 1'b1;
        // Y is loaded only on entry to DONE so it holds its last result elsewhere.
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
          y_d     = step_out;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= SH_SRL;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign Y         = y_q;

endmodule

// File: tb/tb_seq_shifter_32bits.sv
// Randomized and directed bench for seq_shifter_32bits against a plain-operator model.
// Expectations follow SEQ_SHIFTER_ROTATE_EN when the bench is built with it.
module tb_seq_shifter_32bits;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [4:0]  B;
  logic [1:0]  Sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_accept = 0;
  int n_result = 0;

  seq_shifter_32bits dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int b, input logic [1:0] sel);
    case (sel)
      2'b00:   return a >> b;
      2'b01:   return 32'($signed(a) >>> b);
      2'b10:   return a << b;
`ifdef SEQ_SHIFTER_ROTATE_EN
      default: return (a << b) | (a >> (32 - b));
`else
      default: return a << b;
`endif
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, stall, drain.
  task automatic run_op(input logic [31:0] a, input logic [4:0] b, input logic [1:0] sel,
                        input int stall, input bit poke);
    int          lat;
    logic [31:0] exp;
    exp = ref_shift(a, int'(b), sel);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    A = a; B = b; Sel = sel; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_accept++;
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(b) + 32'd1);
    if (out_valid) n_result++;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1; A = ~a; B = 5'd3; Sel = 2'b00;
      end
      tick();
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_y", Y, exp);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("result", Y, exp);
    tick();
    out_ready = 1'b0;
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_y_hold", Y, exp);
  endtask

  initial begin
    bit          saw_valid;
    logic [31:0] ra;
    logic [4:0]  rb;
    logic [1:0]  rs;
    int          rstall;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Sel = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_y", Y, 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);

    run_op(32'h8000_0001, 5'd4, 2'b00, 0, 1'b0);
    check_eq("srl_y", Y, 32'h0800_0000);

    // Abort mid-shift; a request presented with reset must not be taken.
    A = 32'hFFFF_0000; B = 5'd20; Sel = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check_eq("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1; in_valid = 1'b1; A = 32'h1234_5678; B = 5'd2;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_y", Y, 32'h0);
    saw_valid = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid || busy) saw_valid = 1'b1;
    end
    check_eq("abort_no_result", 32'(saw_valid), 32'd0);

    run_op(32'h8000_0000, 5'd31, 2'b01, 1, 1'b0);
    check_eq("sra31_y", Y, 32'hFFFF_FFFF);
    run_op(32'h7000_0000, 5'd28, 2'b01, 0, 1'b0);
    check_eq("sra28_y", Y, 32'h0000_0007);
    run_op(32'h0000_0001, 5'd31, 2'b10, 2, 1'b0);
    check_eq("sll31_y", Y, 32'h8000_0000);
    run_op(32'h8000_0001, 5'd1, 2'b11, 0, 1'b0);
`ifdef SEQ_SHIFTER_ROTATE_EN
    check_eq("sel11_y", Y, 32'h0000_0003);
`else
    check_eq("sel11_y", Y, 32'h0000_0002);
`endif
    run_op(32'hDEAD_BEEF, 5'd0, 2'b01, 5, 1'b1);
    check_eq("zero_shift_y", Y, 32'hDEAD_BEEF);
    check_eq("zero_shift_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 1000; k++) begin
      ra     = $urandom;
      rb     = 5'($urandom_range(0, 31));
      rs     = 2'($urandom_range(0, 3));
      rstall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : 0;
      run_op(ra, rb, rs, rstall, 1'b0);
    end

    check_eq("accepts_vs_results", 32'(n_result), 32'(n_accept));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
